// File: rtl/acc_block_if.sv
// acc_block_if: stream-in / result-out bundle for acc_block.
//   N  : input item width, W : result width, CW : item-count width
//   Upstream side : R_IN (item valid), D_IN (item), FLUSH (close block early)
//   Result side   : R_OUT (one-cycle result valid), D_OUT (block sum), C_OUT (item count)
//   master : the producer/consumer around the block; slave : acc_block itself.
interface acc_block_if #(
   parameter int unsigned N  = 16,
   parameter int unsigned W  = 32,
   parameter int unsigned CW = 17
);
   logic          R_IN;
   logic [N-1:0]  D_IN;
   logic          FLUSH;
   logic          R_OUT;
   logic [W-1:0]  D_OUT;
   logic [CW-1:0] C_OUT;

   modport master (
      output R_IN, D_IN, FLUSH,
      input  R_OUT, D_OUT, C_OUT
   );

   modport slave (
      input  R_IN, D_IN, FLUSH,
      output R_OUT, D_OUT, C_OUT
   );
endinterface

// File: rtl/acc_block.sv
// acc_block: stream reducer. Sums every LEN valid items (or fewer on FLUSH)
// into one W-bit result, emitted with a one-cycle R_OUT pulse and the item
// count on C_OUT. EN stalls all state in lockstep with the feeding stage.
//
// Ports:
//   CLK : clock, rising edge
//   RST : synchronous active-high reset, priority over everything incl. EN
//   EN  : stage enable; low holds all state and outputs
//   bus : acc_block_if.slave (R_IN, D_IN, FLUSH in; R_OUT, D_OUT, C_OUT out)
//
// Build option: define ACC_SATURATE_EN to make the accumulator saturate at
// 2^W-1 instead of wrapping modulo 2^W. Counting/flush/timing are unchanged.
module acc_block #(
   parameter int unsigned N   = 16,
   parameter int unsigned LEN = 8,
   parameter int unsigned W   = 32,
   parameter int unsigned CW  = 17
) (
   input  logic CLK,
   input  logic RST,
   input  logic EN,
   acc_block_if.slave bus
);

   localparam logic [CW-1:0] LEN_C = CW'(LEN);

   // Architectural state and registered outputs
   logic [W-1:0]  acc;
   logic [CW-1:0] cnt;
   logic          r_out_q;
   logic [W-1:0]  d_out_q;
   logic [CW-1:0] c_out_q;

   // Combinational next-values for the current cycle
   logic [W-1:0]  add_c;
   logic [W-1:0]  sum_c;
   logic [CW-1:0] n_c;
   logic          close_c;

   // Adder: wrap or saturate depending on build
`ifdef ACC_SATURATE_EN
   localparam int unsigned WX = W + 1;
   logic [W:0] wide_c;
   assign wide_c = {1'b0, acc} + WX'(bus.D_IN);
   // carry out means the true sum reached 2^W; pin at all-ones
   assign add_c  = wide_c[W] ? {W{1'b1}} : wide_c[W-1:0];
`else
   assign add_c  = acc + W'(bus.D_IN);
`endif

   // Block-close decision for this cycle
   always_comb begin
      sum_c   = acc;
      n_c     = cnt + CW'(bus.R_IN);
      close_c = 1'b0;
      if (bus.R_IN) begin
         sum_c = add_c;
      end
      // an empty flush is ignored so no zero-length result is ever emitted
      if ((n_c == LEN_C) || (bus.FLUSH && (n_c != '0))) begin
         close_c = 1'b1;
      end
   end

   // State update; everything holds while EN is low
   always_ff @(posedge CLK) begin
      if (RST) begin
         acc     <= '0;
         cnt     <= '0;
         r_out_q <= 1'b0;
         d_out_q <= '0;
         c_out_q <= '0;
      end else if (EN) begin
         if (close_c) begin
            acc     <= '0;
            cnt     <= '0;
            r_out_q <= 1'b1;
            d_out_q <= sum_c;
            c_out_q <= n_c;
         end else begin
            acc     <= sum_c;
            cnt     <= n_c;
            r_out_q <= 1'b0;
         end
      end
   end

   assign bus.R_OUT = r_out_q;
   assign bus.D_OUT = d_out_q;
   assign bus.C_OUT = c_out_q;

endmodule
